// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60Hz timing constants, score width and coordinate type
package vga_pkg;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int TICK_DIV  = 4;
  localparam int SCORE_W   = 5;
  typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_sync_counter_if.sv
// vga_sync_counter_if: goal/clear inputs and sync, coordinate and LED outputs
interface vga_sync_counter_if;
  logic                        hit;
  logic                        score_clr;
  logic                        hsync;
  logic                        vsync;
  logic                        video_on;
  logic                        p_tick;
  vga_pkg::coord_t             x;
  vga_pkg::coord_t             y;
  logic [vga_pkg::SCORE_W-1:0] led;
  modport master (input hit, score_clr, output hsync, vsync, video_on, p_tick, x, y, led);
  modport slave  (output hit, score_clr, input hsync, vsync, video_on, p_tick, x, y, led);
endinterface

// File: rtl/vga_sync_counter_score.sv
// score_counter: counts hit rising edges into a saturating thermometer LED code
module score_counter
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               hit,
  input  logic               clr,
  output logic [SCORE_W-1:0] led
);
  logic               hit_q, hit_d;
  logic [SCORE_W-1:0] led_q, led_d;
  always_comb begin
    hit_d = hit;
    led_d = clr ? '0 : (hit && !hit_q) ? {led_q[SCORE_W-2:0], 1'b1} : led_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b0;
      led_q <= '0;
    end else begin
      hit_q <= hit_d;
      led_q <= led_d;
    end
  end
  assign led = led_q;
endmodule

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: VGA pixel tick, x/y scan counters, registered syncs and LED score
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int HD = H_DISPLAY,
  parameter int HF = H_FRONT,
  parameter int HS = H_SYNC,
  parameter int HB = H_BACK,
  parameter int VD = V_DISPLAY,
  parameter int VF = V_FRONT,
  parameter int VS = V_SYNC,
  parameter int VB = V_BACK
) (
  input logic                clk,
  input logic                reset,
  vga_sync_counter_if.master bus
);
  localparam coord_t H_LAST = coord_t'(HD + HF + HS + HB - 1);
  localparam coord_t V_LAST = coord_t'(VD + VF + VS + VB - 1);
  localparam coord_t HS_BEG = coord_t'(HD + HF);
  localparam coord_t HS_END = coord_t'(HD + HF + HS - 1);
  localparam coord_t VS_BEG = coord_t'(VD + VF);
  localparam coord_t VS_END = coord_t'(VD + VF + VS - 1);
  localparam coord_t H_VIS  = coord_t'(HD);
  localparam coord_t V_VIS  = coord_t'(VD);
  logic [1:0] div_q, div_d;
  coord_t     x_q, x_d, y_q, y_d, x_n, y_n;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, p_tick;
  assign p_tick = div_q == 2'(TICK_DIV - 1);
  // syncs are decoded from the next coordinates so they stay aligned with x/y
  always_comb begin
    div_d   = div_q + 2'd1;
    x_n     = (x_q == H_LAST) ? '0 : x_q + 10'd1;
    y_n     = (x_q != H_LAST) ? y_q : (y_q == V_LAST) ? '0 : y_q + 10'd1;
    x_d     = p_tick ? x_n : x_q;
    y_d     = p_tick ? y_n : y_q;
    hsync_d = p_tick ? !(x_n >= HS_BEG && x_n <= HS_END) : hsync_q;
    vsync_d = p_tick ? !(y_n >= VS_BEG && y_n <= VS_END) : vsync_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end
  score_counter u_score (
    .clk  (clk),
    .reset(reset),
    .hit  (bus.hit),
    .clr  (bus.score_clr),
    .led  (bus.led)
  );
  assign bus.p_tick   = p_tick;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.hsync    = hsync_q;
  assign bus.vsync    = vsync_q;
  assign bus.video_on = (x_q < H_VIS) && (y_q < V_VIS);
endmodule

// File: tb/tb_vga_sync_counter.sv
// tb_vga_sync_counter: directed checks of VGA timing (full and shrunk geometry) and scoring
module tb_vga_sync_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  vga_sync_counter_if bus ();
  vga_sync_counter_if bus_s ();
  vga_sync_counter dut (.clk(clk), .reset(reset), .bus(bus));
  // shrunk geometry: line 15 px (hsync x=10..12), frame 12 lines (vsync y=7..8)
  vga_sync_counter #(.HD(8), .HF(2), .HS(3), .HB(2), .VD(6), .VF(1), .VS(2), .VB(3))
    dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  typedef struct {logic hit; logic clr; logic [4:0] led;} vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " x"}, 32'(bus.x), 0);
    check({tag, " y"}, 32'(bus.y), 0);
    check({tag, " p_tick"}, 32'(bus.p_tick), 0);
    check({tag, " hsync"}, 32'(bus.hsync), 1);
    check({tag, " vsync"}, 32'(bus.vsync), 1);
    check({tag, " video_on"}, 32'(bus.video_on), 1);
    check({tag, " led"}, 32'(bus.led), 0);
    check({tag, " small x"}, 32'(bus_s.x), 0);
  endtask

  initial begin
    int hs_cnt, hs_first, von639, von640;
    int vs_cnt, vs_first, ymax, von_y6;
    bit found;
    hs_cnt = 0; hs_first = -1; von639 = -1; von640 = -1;
    vs_cnt = 0; vs_first = -1; ymax = 0; von_y6 = -1;
    bus.hit = 0; bus.score_clr = 0; bus_s.hit = 0; bus_s.score_clr = 0;
    vt.push_back('{1'b1, 1'b0, 5'b00001});
    vt.push_back('{1'b1, 1'b0, 5'b00001});
    vt.push_back('{1'b0, 1'b0, 5'b00001});
    vt.push_back('{1'b1, 1'b0, 5'b00011});
    vt.push_back('{1'b1, 1'b0, 5'b00011});
    vt.push_back('{1'b0, 1'b0, 5'b00011});
    vt.push_back('{1'b1, 1'b0, 5'b00111});
    vt.push_back('{1'b0, 1'b0, 5'b00111});
    vt.push_back('{1'b1, 1'b0, 5'b01111});
    vt.push_back('{1'b0, 1'b0, 5'b01111});
    vt.push_back('{1'b1, 1'b0, 5'b11111});
    vt.push_back('{1'b0, 1'b0, 5'b11111});
    vt.push_back('{1'b1, 1'b0, 5'b11111});
    vt.push_back('{1'b0, 1'b0, 5'b11111});
    vt.push_back('{1'b1, 1'b0, 5'b11111});
    vt.push_back('{1'b0, 1'b0, 5'b11111});
    vt.push_back('{1'b0, 1'b1, 5'b00000});
    vt.push_back('{1'b1, 1'b0, 5'b00001});
    vt.push_back('{1'b0, 1'b0, 5'b00001});
    vt.push_back('{1'b1, 1'b1, 5'b00000});
    vt.push_back('{1'b1, 1'b0, 5'b00000});
    vt.push_back('{1'b0, 1'b0, 5'b00000});
    vt.push_back('{1'b1, 1'b0, 5'b00001});
    vt.push_back('{1'b0, 1'b0, 5'b00001});
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    for (int k = 1; k <= 3200; k++) begin
      @(negedge clk);
      if (k <= 12) begin
        check($sformatf("p_tick clk%0d", k), 32'(bus.p_tick), 32'(k % 4 == 3));
        check($sformatf("x clk%0d", k), 32'(bus.x), 32'(k / 4));
      end
      if (!bus.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(bus.x);
      end
      if (bus.x == 639) von639 = int'(bus.video_on);
      if (bus.x == 640) von640 = int'(bus.video_on);
      if (k == 3199) begin
        check("x before wrap", 32'(bus.x), 799);
        check("y before wrap", 32'(bus.y), 0);
      end
      if (k == 3200) begin
        check("x after wrap", 32'(bus.x), 0);
        check("y after wrap", 32'(bus.y), 1);
      end
      if (k <= 720) begin
        if (!bus_s.vsync) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = int'(bus_s.y);
        end
        if (int'(bus_s.y) > ymax) ymax = int'(bus_s.y);
        if (bus_s.y == 6 && bus_s.x == 0) von_y6 = int'(bus_s.video_on);
      end
      if (k == 719) begin
        check("small x frame end", 32'(bus_s.x), 14);
        check("small y frame end", 32'(bus_s.y), 11);
      end
      if (k == 720) begin
        check("small x frame wrap", 32'(bus_s.x), 0);
        check("small y frame wrap", 32'(bus_s.y), 0);
      end
    end
    check("hsync low clks", 32'(hs_cnt), 384);
    check("hsync first x", 32'(hs_first), 656);
    check("video_on x=639", 32'(von639), 1);
    check("video_on x=640", 32'(von640), 0);
    check("small vsync low clks", 32'(vs_cnt), 120);
    check("small vsync first y", 32'(vs_first), 7);
    check("small y max", 32'(ymax), 11);
    check("small video_on y=6", 32'(von_y6), 0);
    foreach (vt[i]) begin
      bus.hit = vt[i].hit;
      bus.score_clr = vt[i].clr;
      @(negedge clk);
      check($sformatf("led vec%0d", i), 32'(bus.led), 32'(vt[i].led));
    end
    bus.score_clr = 0;
    bus.hit = 1;
    repeat (1000) @(negedge clk);
    check("led held hit", 32'(bus.led), 5'b00011);
    bus.hit = 0;
    @(negedge clk);
    bus.hit = 1;
    repeat (3) @(negedge clk);
    bus.hit = 0;
    @(negedge clk);
    check("led third point", 32'(bus.led), 5'b00111);
    found = 0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge clk);
      if (bus.x == 300) found = 1;
    end
    check("reached x=300", 32'(found), 1);
    check("led before async reset", 32'(bus.led), 5'b00111);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_state("async reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
